// File: rtl/mem_responder.sv
// Word-addressed memory that answers a multicycle CPU's req/ready interface.
// It waits a fixed number of cycles, then reads, writes or rejects the captured request.
module mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              ready,
    output logic              err,
    output logic              busy
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic              bad;
    logic              access;

    // Any set bit above the index field means the word address is past the array.
    assign idx    = adr_q[IDX_W+1:2];
    assign bad    = (adr_q[1:0] != 2'b00) || ((adr_q >> (IDX_W + 2)) != '0);
    assign access = (state_q == BUSY) && (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = BUSY;
                cnt_d   = 4'(WAIT_STATES);
            end
            BUSY: if (cnt_q == 4'd0) state_d = RESP;
                  else               cnt_d   = cnt_q - 4'd1;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (state_q == IDLE && req) begin
                we_q    <= we;
                adr_q   <= adr;
                wdata_q <= writedata;
            end
            if (access) begin
                err_q <= bad;
                if (!bad && !we_q) rdata_q <= mem[idx];
            end
        end
    end

    // Array is deliberately not reset; an async reset forces IDLE so no pending write lands.
    always_ff @(posedge clk) begin
        if (access && we_q && !bad) mem[idx] <= wdata_q;
    end

    always_comb begin
        ready    = (state_q == RESP);
        err      = (state_q == RESP) && err_q;
        busy     = (state_q != IDLE);
        readdata = rdata_q;
    end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: one responder with two wait states, one with none, against an array model.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = '0, writedata = '0;
    logic [31:0] rd_a, rd_b;
    logic        ready_a, ready_b, err_a, err_b, busy_a, busy_b;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] mdl [2][64];
    logic [31:0] mrd [2];

    always #5 clk = ~clk;

    mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_STATES(2)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .we(we), .adr(adr), .writedata(writedata),
        .readdata(rd_a), .ready(ready_a), .err(err_a), .busy(busy_a));

    mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_STATES(0)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we), .adr(adr), .writedata(writedata),
        .readdata(rd_b), .ready(ready_b), .err(err_b), .busy(busy_b));

    // One full transaction on DUT sel (0: two wait states, 1: none), checked against the model.
    task automatic txn(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input string nm);
        int n = 0;
        bit seen = 0;
        bit bad;
        logic r, e, b;
        logic [31:0] rd;
        int ws = (sel == 0) ? 2 : 0;
        we = w; adr = a; writedata = d;
        if (sel == 0) req_a = 1'b1; else req_b = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
        we = 1'($urandom); adr = $urandom; writedata = $urandom;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            r = (sel == 0) ? ready_a : ready_b;
            if (r) seen = 1;
        end
        bad = (a % 4 != 0) || (a >= 32'd256);
        if (!bad) begin
            if (w) mdl[sel][a / 4] = d;
            else   mrd[sel] = mdl[sel][a / 4];
        end
        e  = (sel == 0) ? err_a  : err_b;
        b  = (sel == 0) ? busy_a : busy_b;
        rd = (sel == 0) ? rd_a   : rd_b;
        total_cnt++;
        if (n !== ws + 1) $display("FAIL %s latency: got %0d edges exp %0d", nm, n, ws + 1);
        else pass_cnt++;
        total_cnt++;
        if (e !== bad || b !== 1'b1) $display("FAIL %s err/busy: got %b/%b exp %b/1", nm, e, b, bad);
        else pass_cnt++;
        total_cnt++;
        if (rd !== mrd[sel]) $display("FAIL %s readdata: got %h exp %h", nm, rd, mrd[sel]);
        else pass_cnt++;
        @(posedge clk); #1;
        r = (sel == 0) ? ready_a : ready_b;
        e = (sel == 0) ? err_a   : err_b;
        b = (sel == 0) ? busy_a  : busy_b;
        total_cnt++;
        if (r !== 1'b0 || e !== 1'b0 || b !== 1'b0)
            $display("FAIL %s after-resp: got ready/err/busy %b/%b/%b exp 0/0/0", nm, r, e, b);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++;
        if (ready_a !== 1'b0 || err_a !== 1'b0 || busy_a !== 1'b0 || rd_a !== 32'h0 ||
            ready_b !== 1'b0 || err_b !== 1'b0 || busy_b !== 1'b0 || rd_b !== 32'h0)
            $display("FAIL reset_state: got a %b%b%b %h b %b%b%b %h exp all zero",
                     ready_a, err_a, busy_a, rd_a, ready_b, err_b, busy_b, rd_b);
        else pass_cnt++;
        mrd[0] = '0; mrd[1] = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 64; i++) txn(s, 1'b1, 32'(i * 4), $urandom, "fill");
    endtask

    task automatic test_write_read();
        txn(0, 1'b1, 32'h10, 32'h12345678, "wr_0x10");
        txn(0, 1'b0, 32'h10, 32'h0, "rd_0x10");
        total_cnt++;
        if (rd_a !== 32'h12345678) $display("FAIL rd_0x10_const: got %h exp 12345678", rd_a);
        else pass_cnt++;
    endtask

    task automatic test_zero_wait();
        txn(1, 1'b1, 32'h0, 32'hA5A5A5A5, "zw_wr");
        txn(1, 1'b0, 32'h0, 32'h0, "zw_rd");
        total_cnt++;
        if (rd_b !== 32'hA5A5A5A5) $display("FAIL zw_rd_const: got %h exp a5a5a5a5", rd_b);
        else pass_cnt++;
    endtask

    task automatic test_errors();
        txn(0, 1'b1, 32'h12, 32'hDEADBEEF, "misaligned_wr");
        txn(0, 1'b0, 32'h10, 32'h0, "rd_after_misaligned");
        total_cnt++;
        if (rd_a !== 32'h12345678) $display("FAIL misaligned_kept: got %h exp 12345678", rd_a);
        else pass_cnt++;
        txn(0, 1'b0, 32'h100, 32'h0, "oor_rd");
        txn(1, 1'b0, 32'h102, 32'h0, "oor_misaligned_rd_b");
    endtask

    task automatic test_boundary();
        txn(0, 1'b1, 32'hFC, 32'h0BADF00D, "last_wr");
        txn(0, 1'b0, 32'hFC, 32'h0, "last_rd");
        txn(0, 1'b1, 32'h100, 32'h11112222, "oor_wr");
        txn(0, 1'b0, 32'h0, 32'h0, "oor_wr_no_wrap");
        txn(1, 1'b1, 32'hFC, 32'h77778888, "last_wr_b");
        txn(1, 1'b0, 32'hFC, 32'h0, "last_rd_b");
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int last_edge = 0;
        int cyc = 0;
        logic [31:0] exp_adr = 32'h0;
        we = 1'b0; adr = 32'h0; req_a = 1'b1;
        while (pulses < 6 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (ready_a) begin
                mrd[0] = mdl[0][exp_adr / 4];
                total_cnt++;
                if (rd_a !== mrd[0] || err_a !== 1'b0)
                    $display("FAIL b2b_data: got %h err %b exp %h err 0", rd_a, err_a, mrd[0]);
                else pass_cnt++;
                if (pulses > 0) begin
                    total_cnt++;
                    if (cyc - last_edge !== 5)
                        $display("FAIL b2b_spacing: got %0d cycles exp 5", cyc - last_edge);
                    else pass_cnt++;
                end
                last_edge = cyc;
                pulses++;
                exp_adr = (exp_adr == 32'h0) ? 32'h4 : 32'h0;
                adr = exp_adr; we = 1'b0;
                if (pulses == 6) req_a = 1'b0;
            end else if (busy_a) begin
                adr = $urandom; we = 1'($urandom);
            end
        end
        req_a = 1'b0;
        total_cnt++;
        if (pulses !== 6) $display("FAIL b2b_timeout: got %0d pulses exp 6", pulses);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] a;
        int k;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            if (k < 7)      a = 32'($urandom_range(0, 63) * 4);
            else if (k < 9) a = 32'($urandom_range(0, 255));
            else            a = 32'h100 + 32'($urandom_range(0, 4095));
            txn(i % 2, 1'($urandom), a, $urandom, "random");
        end
    endtask

    task automatic test_reset_mid_write();
        int pulses = 0;
        txn(0, 1'b1, 32'h8, 32'h0, "prewrite_0x8");
        we = 1'b1; adr = 32'h8; writedata = 32'hCAFEF00D; req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        mrd[0] = '0; mrd[1] = '0;
        total_cnt++;
        if (ready_a !== 1'b0 || err_a !== 1'b0 || busy_a !== 1'b0 || rd_a !== 32'h0 || rd_b !== 32'h0)
            $display("FAIL midreset_state: got %b%b%b %h/%h exp 000 0/0",
                     ready_a, err_a, busy_a, rd_a, rd_b);
        else pass_cnt++;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ready_a || busy_a) pulses++;
        end
        total_cnt++;
        if (pulses !== 0) $display("FAIL midreset_no_ready: got %0d active cycles exp 0", pulses);
        else pass_cnt++;
        txn(0, 1'b0, 32'h8, 32'h0, "rd_after_abort");
        total_cnt++;
        if (rd_a === 32'hCAFEF00D) $display("FAIL abort_committed: got %h exp 00000000", rd_a);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_zero_wait();
        test_errors();
        test_boundary();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed data/instruction memory acting as the responding end of the multicycle CPU's memory interface.
- Accepts one read or write request at a time over a req/ready handshake.
- Inserts a configurable number of wait states, then returns read data or commits the write.
- Flags misaligned or out-of-range accesses with an error pulse instead of touching the array.

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 32, byte-address width in bits
DEPTH, 64, number of words in the array; power of two, minimum 2
WAIT_STATES, 2, extra cycles between acceptance and access; 0..15

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  1  request valid; sampled only in IDLE
we  input  1  1 = write, 0 = read; captured with req
adr  input  ADDR_W  byte address; captured with req
writedata  input  DATA_W  write data; captured with req
readdata  output  DATA_W  read result; holds until the next successful read completes
ready  output  1  one-cycle response strobe
err  output  1  valid only while ready=1; 1 = access rejected
busy  output  1  1 in every state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ready=0, err=0, busy=0, readdata=0, wait counter=0.
  - Array contents are not reset.
  - Reset asserted mid-transaction aborts it; a write not yet at its ACCESS edge is never committed.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If req=1 at a rising edge, capture we/adr/writedata into internal registers, load cnt=WAIT_STATES, go to BUSY.
  - If req=0, stay in IDLE.
- BUSY:
  - If cnt!=0, decrement cnt and stay in BUSY.
  - If cnt==0, perform the ACCESS edge and go to RESP.
- ACCESS edge:
  - Compute index=cap_adr[log2(DEPTH)+1:2].
  - Set bad=1 if cap_adr[1:0]!=0, or if any cap_adr bit above index is nonzero (word address >= DEPTH).
  - bad=1: no array write, readdata unchanged, err<=1.
  - Read and bad=0: readdata<=mem[index], err<=0.
  - Write and bad=0: mem[index]<=cap_writedata, readdata unchanged, err<=0.
- RESP: ready=1 for exactly one cycle with err valid; go to IDLE. req is not sampled in RESP.
- Latency: for acceptance at edge T, ready is high in the cycle after edge T+WAIT_STATES+1.
  - With WAIT_STATES=0, ready is high in the cycle after edge T+1.
- Throughput: one transaction per WAIT_STATES+3 cycles at most.
- Inputs may change freely after acceptance; only captured values are used.
- The requester holds req until it sees ready, then drops or re-raises req. A req still high in the IDLE cycle after RESP starts a new transaction.
- ready and err are 0 outside RESP. busy=1 in BUSY and RESP.
- A write followed by a read to the same address returns the new data. There is no bypass hazard because accesses are serialized.

Test Plan:
- Reset mid-BUSY write (WAIT_STATES=2): write adr=0x8, data=0xCAFEF00D; pull reset low one edge after acceptance -> ready never pulses, outputs return to reset values; a later read of 0x8 does not return 0xCAFEF00D (array pre-written with 0x0 beforehand).
- Write then read (WAIT_STATES=2): write adr=0x10, data=0x12345678; read adr=0x10 -> each ready appears 3 edges after acceptance, readdata=0x12345678, err=0.
- Zero wait (WAIT_STATES=0): write then read adr=0x0, data=0xA5A5A5A5 -> ready one edge after the BUSY entry edge, readdata=0xA5A5A5A5.
- Misaligned write adr=0x12 -> ready with err=1, and a subsequent read of 0x10 still returns the prior value. Out-of-range read adr=0x100 (DEPTH=64) -> err=1, readdata unchanged.
- req held high continuously with alternating reads of 0x0/0x4 -> transactions spaced exactly WAIT_STATES+3 cycles; changing adr during BUSY does not affect the result.
- Boundary: write/read last word adr=0xFC (DEPTH=64) -> err=0, data correct. adr=0x100 -> err=1.
